// File: rtl/sym_conv_mac.sv
`default_nettype none
//==============================================================================
// Module   : sym_conv_mac
// Brief    : Symmetric-kernel convolution MAC. Folded taps are multiplied by a
//            double-buffered coefficient bank and summed by a pipelined adder
//            tree, then rounded, normalised and saturated.
// Revision : 1.0 - initial release
//==============================================================================
module sym_conv_mac #(
    parameter int KERNEL_SIZE = 11,
    parameter int DATA_W      = 8,
    parameter int TAP_W       = DATA_W + 3,
    parameter int COEF_W      = 8,
    parameter int NUM_TAPS    = 1 + (KERNEL_SIZE - 1) + (KERNEL_SIZE - 1) * (KERNEL_SIZE - 3) / 8,
    parameter int NORM_SHIFT  = 8,
    parameter int OUT_W       = 16,
    parameter logic [NUM_TAPS*COEF_W-1:0] COEF_INIT =
        {{((NUM_TAPS - 1) * COEF_W){1'b0}}, COEF_W'(255)},
    parameter int ACC_W       = TAP_W + COEF_W + $clog2(NUM_TAPS)
) (
    input  logic                        axi_clk,
    input  logic                        axi_rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [NUM_TAPS*TAP_W-1:0]   s_taps,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [OUT_W-1:0]            m_data,
    output logic                        m_last,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]           coef_wdata,
    input  logic                        coef_commit,
    input  logic                        sat_clr,
    output logic                        sat_flag,
    output logic                        busy
);

    // Node count of tree level lvl (level 0 = products) and its offset in w_tree.
    function automatic int lvl_cnt(input int lvl);
        return (NUM_TAPS + (1 << lvl) - 1) >> lvl;
    endfunction

    function automatic int lvl_off(input int lvl);
        int s;
        s = 0;
        for (int k = 0; k < lvl; k++) s += lvl_cnt(k);
        return s;
    endfunction

    function automatic logic [ACC_W:0] rnd_bias(input int sh);
        if (sh == 0) return '0;
        return (ACC_W + 1)'(1) << (sh - 1);
    endfunction

    localparam int              c_lvls   = $clog2(NUM_TAPS);
    localparam int              c_addr_w = $clog2(NUM_TAPS);
    localparam int              c_nodes  = lvl_off(c_lvls + 1);
    localparam logic [ACC_W:0]  c_round  = rnd_bias(NORM_SHIFT);

    logic                     w_en;
    logic [c_nodes*ACC_W-1:0] w_tree;
    logic [c_lvls:0]          w_vld;
    logic [c_lvls:0]          w_lst;

    logic [COEF_W-1:0]        r_shadow [NUM_TAPS];
    logic [COEF_W-1:0]        r_active [NUM_TAPS];
    logic [NUM_TAPS*ACC_W-1:0] r_prod;
    logic                     r_prod_vld;
    logic                     r_prod_lst;

    logic [ACC_W:0]           w_rnd;
    logic [ACC_W:0]           w_norm;
    logic                     w_sat;
    logic                     r_m_valid;
    logic                     r_m_last;
    logic [OUT_W-1:0]         r_m_data;
    logic                     r_sat;

    assign w_en    = !r_m_valid || m_ready;
    assign s_ready = w_en;

    // Commit copies the shadow as it stood before any write in the same cycle.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_shadow[i] <= COEF_INIT[i*COEF_W +: COEF_W];
                r_active[i] <= COEF_INIT[i*COEF_W +: COEF_W];
            end
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (coef_we && coef_addr == c_addr_w'(i)) r_shadow[i] <= coef_wdata;
                if (coef_commit) r_active[i] <= r_shadow[i];
            end
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_prod_lst <= 1'b0;
        end else if (w_en) begin
            r_prod_vld <= s_valid;
            r_prod_lst <= s_valid && s_last;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_prod[i*ACC_W +: ACC_W] <= ACC_W'(s_taps[i*TAP_W +: TAP_W]) * ACC_W'(r_active[i]);
            end
        end
    end

    assign w_tree[0 +: NUM_TAPS*ACC_W] = r_prod;
    assign w_vld[0]                    = r_prod_vld;
    assign w_lst[0]                    = r_prod_lst;

    for (genvar l = 1; l <= c_lvls; l++) begin : g_lvl
        localparam int c_nin  = lvl_cnt(l - 1);
        localparam int c_nout = lvl_cnt(l);
        localparam int c_oin  = lvl_off(l - 1);
        localparam int c_oout = lvl_off(l);

        logic [c_nout*ACC_W-1:0] r_sum;
        logic                    r_vld;
        logic                    r_lst;

        always_ff @(posedge axi_clk or posedge axi_rst) begin
            if (axi_rst) begin
                r_sum <= '0;
                r_vld <= 1'b0;
                r_lst <= 1'b0;
            end else if (w_en) begin
                r_vld <= w_vld[l-1];
                r_lst <= w_lst[l-1];
                for (int j = 0; j < c_nout; j++) begin
                    if (2 * j + 1 < c_nin)
                        r_sum[j*ACC_W +: ACC_W] <= w_tree[(c_oin + 2*j)*ACC_W +: ACC_W]
                                                 + w_tree[(c_oin + 2*j + 1)*ACC_W +: ACC_W];
                    else
                        r_sum[j*ACC_W +: ACC_W] <= w_tree[(c_oin + 2*j)*ACC_W +: ACC_W];
                end
            end
        end

        assign w_tree[c_oout*ACC_W +: c_nout*ACC_W] = r_sum;
        assign w_vld[l]                             = r_vld;
        assign w_lst[l]                             = r_lst;
    end

    assign w_rnd  = {1'b0, w_tree[(c_nodes-1)*ACC_W +: ACC_W]} + c_round;
    assign w_norm = w_rnd >> NORM_SHIFT;
    assign w_sat  = (w_norm >> OUT_W) != '0;

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else if (w_en) begin
            r_m_valid <= w_vld[c_lvls];
            r_m_last  <= w_lst[c_lvls];
            r_m_data  <= w_sat ? '1 : w_norm[OUT_W-1:0];
        end
    end

    // A saturating beat landing in the output register beats a concurrent clear.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst)                             r_sat <= 1'b0;
        else if (w_en && w_vld[c_lvls] && w_sat) r_sat <= 1'b1;
        else if (sat_clr)                        r_sat <= 1'b0;
    end

    assign m_valid  = r_m_valid;
    assign m_last   = r_m_last;
    assign m_data   = r_m_data;
    assign sat_flag = r_sat;
    assign busy     = (|w_vld) | r_m_valid;

endmodule
`default_nettype wire

// File: doc/sym_conv_mac.md
Name: sym_conv_mac

Overview:
- Parametrised successor of the fixed 11x11 symmetric Gaussian MAC.
- Takes pre-folded symmetric pixel sums (centre, 4-fold and 8-fold groups) from the line-buffer/folding stage and multiplies each by a runtime-loadable coefficient.
- Reduces the products through a pipelined adder tree, then rounds, normalises and saturates.
- Sits between the window/folding logic and the DoG/pyramid stage. Adds a valid/ready handshake with backpressure and a line-end sideband.

Parameters:
- KERNEL_SIZE, 11, odd kernel size K (>=5).
- DATA_W, 8, pixel width.
- TAP_W, DATA_W+3, width of each folded tap input (holds a sum of up to 8 pixels).
- COEF_W, 8, unsigned coefficient width.
- NUM_TAPS, 1+(K-1)+(K-1)*(K-3)/8 (=21), derived. Tap 0 is the centre, taps 1..K-1 are the 4-fold groups, the rest are the 8-fold groups.
- NORM_SHIFT, 8, right shift applied after accumulation (0 allowed).
- OUT_W, 16, output width.
- COEF_INIT, {NUM_TAPS{8'd0}} with tap0=255, reset value of the coefficient banks.
- ACC_W, TAP_W+COEF_W+$clog2(NUM_TAPS), derived accumulator width.

Ports:
- axi_clk  in  1  clock
- axi_rst  in  1  asynchronous active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- s_taps  in  NUM_TAPS*TAP_W  packed folded taps, tap i at [i*TAP_W +: TAP_W], unsigned
- s_last  in  1  last pixel of line, passed through
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts
- m_data  out  OUT_W  normalised, saturated result
- m_last  out  1  s_last aligned with m_data
- coef_we  in  1  write shadow coefficient
- coef_addr  in  $clog2(NUM_TAPS)  shadow index
- coef_wdata  in  COEF_W  shadow value
- coef_commit  in  1  copy shadow bank to active bank
- sat_clr  in  1  clear sticky saturation flag
- sat_flag  out  1  sticky: at least one result saturated
- busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- Reset (async assert, sync release): all stage valids, m_valid, m_last, m_data, sat_flag, busy = 0. Shadow and active banks = COEF_INIT.
- Pipeline enable: en = !m_valid || m_ready. s_ready = en (combinational from m_ready). A beat is accepted when s_valid && s_ready.
- Stalls freeze every stage, data and valid alike. Bubbles are not squeezed out. No beat is lost or duplicated.
- Stage 1: prod[i] = s_taps[i] * active[i], registered at acceptance using the active bank value in that same cycle.
- Stages 2..1+L, where L = $clog2(NUM_TAPS): binary adder tree, one level per stage. Odd leftovers pass through a register. All widths are ACC_W, so there is no overflow internally.
- Final stage:
  - r = (acc + (NORM_SHIFT>0 ? 2^(NORM_SHIFT-1) : 0)) >> NORM_SHIFT, computed in ACC_W+1 bits.
  - If r > 2^OUT_W-1, then m_data = all ones and sat_flag is set. Otherwise m_data = r[OUT_W-1:0].
- Latency: 2+L cycles from acceptance to m_valid when never stalled (7 for the defaults). Throughput is 1 beat/cycle.
- m_last follows its beat through every stage unchanged.
- coef_we: writes shadow[coef_addr] at the clock edge. Addresses >= NUM_TAPS are ignored.
- coef_commit: active <= shadow at the edge. Beats accepted in the commit cycle use the old bank; beats accepted later use the new bank. In-flight beats are unaffected.
- coef_we and coef_commit in the same cycle: the commit copies the pre-write shadow. The write lands in shadow only.
- sat_clr and a new saturation event in the same cycle: set wins.
- busy = OR of all stage valid bits, including m_valid.
- Reset asserted mid-stream: everything in flight is discarded immediately. Coefficient banks return to COEF_INIT.

Test Plan:
- Defaults, tap0=100, other taps 0, coef0=255 → m_data=100 ((25500+128)>>8), m_valid exactly 7 cycles after acceptance, m_last echoes s_last=1.
- Burst of 30 back-to-back beats with m_ready=1 → 30 results in order, one per cycle, s_ready stays 1, each result equal to the reference-model MAC.
- Same burst with m_ready toggled in a 3-on/2-off pattern → no loss or duplication, m_data/m_last stable while m_valid && !m_ready, s_ready=0 whenever m_valid && !m_ready.
- Write shadow[0]=128 with no commit, send tap0=100 → 100. Then commit in the same cycle as the next beat → that beat still gives 100, the following beat gives 50.
- OUT_W=8 override, all taps 2047, all coefs 255 → m_data=255, sat_flag=1 held until sat_clr. sat_clr coinciding with another saturating beat → flag remains 1.
- Assert axi_rst with 4 beats in flight → m_valid, busy and sat_flag drop immediately, no results after release, coef0 reads back as 255 (tap0=100 → 100).
